// File: rtl/oled_i2c_target.sv
// oled_i2c_target: write-only I2C target that splits SSD1306 control bytes from payload and strobes each payload byte
module oled_i2c_target #(
  parameter logic [6:0] ADDR = 7'h3C,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_t,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       xfer_active,
  output logic [7:0] nack_count
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_CTRL, S_CTRL_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;
  state_t state_q;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_dly_q, sda_dly_q, scl_s, sda_s;
  logic scl_rise, scl_fall, start, stop;
  logic [7:0] shift_q, byte_data_q, nack_count_q;
  logic [3:0] cnt_q;
  logic co_q, sda_t_q, byte_valid_q, byte_is_data_q, xfer_active_q;
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_dly_q;
  assign scl_fall = ~scl_s & scl_dly_q;
  assign start = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop = scl_s & scl_dly_q & ~sda_dly_q & sda_s;
  assign sda_o = 1'b0;
  assign scl_o = 1'b0;
  assign scl_t = 1'b1;
  assign sda_t = sda_t_q;
  assign byte_valid = byte_valid_q;
  assign byte_data = byte_data_q;
  assign byte_is_data = byte_is_data_q;
  assign xfer_active = xfer_active_q;
  assign nack_count = nack_count_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q <= 1'b1;
      sda_dly_q <= 1'b1;
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q <= '0;
      co_q <= 1'b0;
      sda_t_q <= 1'b1;
      byte_valid_q <= 1'b0;
      byte_data_q <= '0;
      byte_is_data_q <= 1'b0;
      xfer_active_q <= 1'b0;
      nack_count_q <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q <= scl_s;
      sda_dly_q <= sda_s;
      byte_valid_q <= 1'b0;
      if (start) begin
        state_q <= S_ADDR;
        cnt_q <= '0;
        sda_t_q <= 1'b1;
        xfer_active_q <= 1'b0;
      end else if (stop) begin
        state_q <= S_IDLE;
        sda_t_q <= 1'b1;
        xfer_active_q <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR, S_CTRL, S_DATA: begin
            if (scl_rise && cnt_q != 4'd8) begin
              shift_q <= {shift_q[6:0], sda_s};
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              // Byte complete: the ACK slot starts on this falling edge
              cnt_q <= '0;
              if (state_q == S_ADDR) begin
                if (shift_q == {ADDR, 1'b0}) begin
                  sda_t_q <= 1'b0;
                  xfer_active_q <= 1'b1;
                  state_q <= S_ADDR_ACK;
                end else begin
                  nack_count_q <= nack_count_q + {7'd0, nack_count_q != 8'hFF};
                  state_q <= S_IGNORE;
                end
              end else if (state_q == S_CTRL) begin
                co_q <= shift_q[7];
                byte_is_data_q <= shift_q[6];
                sda_t_q <= 1'b0;
                state_q <= S_CTRL_ACK;
              end else begin
                byte_valid_q <= 1'b1;
                byte_data_q <= shift_q;
                sda_t_q <= 1'b0;
                state_q <= S_DATA_ACK;
              end
            end
          end
          S_ADDR_ACK, S_CTRL_ACK, S_DATA_ACK: begin
            if (scl_fall) begin
              sda_t_q <= 1'b1;
              state_q <= (state_q == S_ADDR_ACK) ? S_CTRL :
                         (state_q == S_CTRL_ACK) ? S_DATA :
                         co_q ? S_CTRL : S_DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_oled_i2c_target.sv
// tb_oled_i2c_target: bit-banged I2C controller driving the target, checked against table vectors and a byte-level model
module tb_oled_i2c_target;
  localparam int Q = 8;
  logic clk = 1'b0, reset = 1'b0, scl_m = 1'b1, sda_m = 1'b1, sda_bus;
  logic sda_o, sda_t, scl_o, scl_t, byte_valid, byte_is_data, xfer_active;
  logic [7:0] byte_data, nack_count;
  int n_chk = 0, n_fail = 0;
  logic [8:0] got_q[$], exp_q[$];
  logic [7:0] ack_got, exp_ack, nack_exp;
  logic xfer_got;
  int exp_ninc;
  typedef struct {
    int n;
    logic [63:0] b;
    int ns;
    logic [35:0] s;
    logic [7:0] ack;
    logic [7:0] nack;
  } vec_t;
  vec_t vt[5];

  assign sda_bus = sda_m & sda_t;

  oled_i2c_target dut (
    .clk(clk), .reset(reset), .sda_i(sda_bus), .sda_o(sda_o), .sda_t(sda_t),
    .scl_i(scl_m), .scl_o(scl_o), .scl_t(scl_t), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_is_data(byte_is_data), .xfer_active(xfer_active),
    .nack_count(nack_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset && byte_valid) got_q.push_back({byte_is_data, byte_data});

  task automatic wq(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic i2c_start();
    if (!scl_m) begin
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
    end
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wq(Q);
    scl_m = 1'b1; wq(2 * Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    ack = ~sda_bus; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic xfer(input int n, input logic [63:0] b);
    logic a;
    ack_got = '0;
    xfer_got = 1'b0;
    got_q.delete();
    i2c_start();
    for (int i = 0; i < n; i++) begin
      send_byte(b[8*i+:8], a);
      ack_got[i] = a;
      if (i == 0) xfer_got = xfer_active;
    end
    i2c_stop();
    wq(4 * Q);
  endtask

  // Byte-level view: address decides everything, then control bytes steer how many payload bytes follow
  task automatic model(input int n, input logic [63:0] b);
    logic [7:0] c;
    int i;
    exp_q.delete();
    exp_ack = '0;
    exp_ninc = 0;
    if (b[7:0] != 8'h78) exp_ninc = 1;
    else begin
      exp_ack = 8'((1 << n) - 1);
      i = 1;
      while (i < n) begin
        c = b[8*i+:8];
        i++;
        if (c[7]) begin
          if (i < n) begin
            exp_q.push_back({c[6], b[8*i+:8]});
            i++;
          end
        end else begin
          while (i < n) begin
            exp_q.push_back({c[6], b[8*i+:8]});
            i++;
          end
        end
      end
    end
  endtask

  initial begin
    vt[0] = '{4, 64'hD5AE0078, 2, {18'h0, 9'h0D5, 9'h0AE}, 8'h0F, 8'd0};
    vt[1] = '{6, 64'hAFBEADDE4078, 4, {9'h1AF, 9'h1BE, 9'h1AD, 9'h1DE}, 8'h3F, 8'd0};
    vt[2] = '{5, 64'h55C0218078, 2, {18'h0, 9'h155, 9'h021}, 8'h1F, 8'd0};
    vt[3] = '{3, 64'hAE007A, 0, 36'h0, 8'h00, 8'd1};
    vt[4] = '{3, 64'h114079, 0, 36'h0, 8'h00, 8'd2};
    wq(3);
    chk("rst_sda_t", 64'(sda_t), 64'(1'b1));
    chk("rst_valid", 64'(byte_valid), 64'(1'b0));
    chk("rst_data", 64'(byte_data), 64'(8'h00));
    chk("rst_xfer", 64'(xfer_active), 64'(1'b0));
    chk("rst_nack", 64'(nack_count), 64'(8'h00));
    chk("const_lines", 64'({sda_o, scl_o, scl_t}), 64'(3'b001));
    reset = 1'b1;
    wq(Q);
    for (int v = 0; v < 5; v++) begin
      xfer(vt[v].n, vt[v].b);
      chk($sformatf("v%0d_ack", v), 64'(ack_got), 64'(vt[v].ack));
      chk($sformatf("v%0d_xfer_on", v), 64'(xfer_got), 64'(vt[v].ack[0]));
      chk($sformatf("v%0d_nstrobe", v), 64'(got_q.size()), 64'(vt[v].ns));
      for (int k = 0; k < vt[v].ns && k < got_q.size(); k++)
        chk($sformatf("v%0d_strobe%0d", v, k), 64'(got_q[k]), 64'(vt[v].s[9*k+:9]));
      chk($sformatf("v%0d_nack", v), 64'(nack_count), 64'(vt[v].nack));
      chk($sformatf("v%0d_xfer_off", v), 64'(xfer_active), 64'(1'b0));
      chk($sformatf("v%0d_released", v), 64'(sda_t), 64'(1'b1));
    end
    begin
      logic a;
      got_q.delete();
      i2c_start();
      send_byte(8'h78, a);
      send_byte(8'h40, a);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      i2c_start();
      chk("rs_xfer_drop", 64'(xfer_active), 64'(1'b0));
      send_byte(8'h78, a);
      chk("rs_addr_ack", 64'(a), 64'(1'b1));
      send_byte(8'h00, a);
      send_byte(8'hAF, a);
      i2c_stop();
      wq(4 * Q);
      chk("rs_nstrobe", 64'(got_q.size()), 64'd1);
      if (got_q.size() > 0) chk("rs_strobe", 64'(got_q[0]), 64'(9'h0AF));
    end
    nack_exp = 8'd2;
    for (int r = 0; r < 12; r++) begin
      logic [63:0] b;
      int n;
      b = {$urandom, $urandom};
      n = $urandom_range(1, 8);
      if ($urandom_range(0, 3) != 0) b[7:0] = 8'h78;
      model(n, b);
      nack_exp = nack_exp + 8'(exp_ninc);
      xfer(n, b);
      chk($sformatf("r%0d_ack", r), 64'(ack_got), 64'(exp_ack));
      chk($sformatf("r%0d_nstrobe", r), 64'(got_q.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
        chk($sformatf("r%0d_strobe%0d", r, k), 64'(got_q[k]), 64'(exp_q[k]));
      chk($sformatf("r%0d_nack", r), 64'(nack_count), 64'(nack_exp));
    end
    begin
      int t = 0;
      got_q.delete();
      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(1'(8'h78 >> i));
      while (sda_t && t < 40) begin wq(1); t++; end
      chk("mid_ack_pull", 64'(sda_t), 64'(1'b0));
      reset = 1'b0;
      #1;
      chk("mid_rst_sda_t", 64'(sda_t), 64'(1'b1));
      chk("mid_rst_outs", 64'({byte_valid, byte_is_data, xfer_active, byte_data, nack_count}), 64'd0);
      wq(2);
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      reset = 1'b1; wq(Q);
      xfer(3, 64'hAE0078);
      chk("post_rst_ack", 64'(ack_got), 64'(8'h07));
      chk("post_rst_nstrobe", 64'(got_q.size()), 64'd1);
      if (got_q.size() > 0) chk("post_rst_strobe", 64'(got_q[0]), 64'(9'h0AE));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
